// File: rtl/key_filter_pkg.sv
// Shared definitions for the push-button debounce filter: FSM state encodings
// and the logical meaning of the active-low key level.
package key_filter_pkg;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_FILTER_DOWN = 2'd1,
        S_DOWN        = 2'd2,
        S_FILTER_UP   = 2'd3
    } state_e;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_filter_sync_edge.sv
// Three-flop synchroniser for an asynchronous pin with falling/rising edge detect.
// Resets to all ones so an idle active-low pin never reports an edge after reset.
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic nedge_o,
    output logic pedge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], pin_i};
        end
    end

    // sync_q[2] is the older sample, sync_q[1] the newer one
    assign nedge_o = sync_q[2] & ~sync_q[1];
    assign pedge_o = ~sync_q[2] & sync_q[1];

endmodule

// File: rtl/key_filter.sv
// Debounces one active-low push-button into a clean level (key_state) and a
// one-cycle strobe (key_flag) for every confirmed press or release.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic Clk50M,
    input  logic Rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       nedge;
    logic       pedge;
    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       flag_q, flag_d;
    logic       level_q, level_d;
    logic       cntDone;

    sync_edge u_sync_edge (
        .clk_i   (Clk50M),
        .rst_i   (Rst),
        .pin_i   (key_in),
        .nedge_o (nedge),
        .pedge_o (pedge)
    );

    assign cntDone = (cnt_q == CNT_LAST);

    always_ff @(posedge Clk50M) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            level_q <= KEY_RELEASED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            level_q <= level_d;
        end
    end

    // An opposite edge always beats the counter terminal: the filter restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (nedge) state_d = S_FILTER_DOWN;
            end
            S_FILTER_DOWN: begin
                if (pedge)        state_d = S_IDLE;
                else if (cntDone) state_d = S_DOWN;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DOWN: begin
                if (pedge) state_d = S_FILTER_UP;
            end
            S_FILTER_UP: begin
                if (nedge)        state_d = S_DOWN;
                else if (cntDone) state_d = S_IDLE;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flag_d  = 1'b0;
        level_d = level_q;
        if (state_q == S_FILTER_DOWN && !pedge && cntDone) begin
            flag_d  = 1'b1;
            level_d = KEY_PRESSED;
        end else if (state_q == S_FILTER_UP && !nedge && cntDone) begin
            flag_d  = 1'b1;
            level_d = KEY_RELEASED;
        end
    end

    assign key_flag  = flag_q;
    assign key_state = level_q;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a 16-cycle window: checks reset, clean and
// bouncy press/release, glitches, short pulses and reset during filtering.
module tb_key_filter;

    localparam int DEB = 16;
    localparam int LAT = DEB + 2;

    logic clk;
    logic rst;
    logic keyIn;
    logic keyFlag;
    logic keyState;

    int vectorCount = 0;
    int missCount   = 0;
    int edgeCnt     = 0;
    int flagCount   = 0;
    int lastFlagEdge = -1;
    int lastFlagState = -1;

    key_filter #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (5)
    ) dut (
        .Clk50M    (clk),
        .Rst       (rst),
        .key_in    (keyIn),
        .key_flag  (keyFlag),
        .key_state (keyState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    // Records every strobe with the index of the edge that produced it.
    always @(negedge clk) begin
        if (keyFlag === 1'b1) begin
            flagCount++;
            lastFlagEdge  = edgeCnt;
            lastFlagState = int'(keyState);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, output int nextEdge);
        @(negedge clk);
        #1;
        keyIn    = v;
        nextEdge = edgeCnt + 1;
    endtask

    initial begin
        int n;
        int base;
        rst   = 1'b1;
        keyIn = 1'b1;

        // Test 1: reset behaviour
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("reset_flag", int'(keyFlag), 0);
            checkOutput("reset_state", int'(keyState), 1);
        end
        rst = 1'b0;
        waitCycles(6);
        checkOutput("idle_noflag", flagCount, 0);
        checkOutput("idle_state", int'(keyState), 1);

        // Test 2: clean press
        base = flagCount;
        applyStimulus(1'b0, n);
        waitCycles(LAT - 2);
        checkOutput("press_not_early", flagCount - base, 0);
        waitCycles(8);
        checkOutput("press_count", flagCount - base, 1);
        checkOutput("press_edge", lastFlagEdge, n + LAT);
        checkOutput("press_flagstate", lastFlagState, 0);
        checkOutput("press_flag_low", int'(keyFlag), 0);
        checkOutput("press_state", int'(keyState), 0);

        // Test 5a: clean release
        base = flagCount;
        applyStimulus(1'b1, n);
        waitCycles(25);
        checkOutput("release_count", flagCount - base, 1);
        checkOutput("release_edge", lastFlagEdge, n + LAT);
        checkOutput("release_state", int'(keyState), 1);

        // Test 3: bounce 5 low, 3 high, then low held
        base = flagCount;
        applyStimulus(1'b0, n);
        waitCycles(4);
        applyStimulus(1'b1, n);
        waitCycles(2);
        applyStimulus(1'b0, n);
        waitCycles(25);
        checkOutput("bounce_count", flagCount - base, 1);
        checkOutput("bounce_edge", lastFlagEdge, n + LAT);
        checkOutput("bounce_state", int'(keyState), 0);

        // Test 4: 10-cycle release glitch while pressed
        base = flagCount;
        applyStimulus(1'b1, n);
        waitCycles(9);
        applyStimulus(1'b0, n);
        waitCycles(25);
        checkOutput("glitch_count", flagCount - base, 0);
        checkOutput("glitch_state", int'(keyState), 0);

        // Test 5b: release, then a 15-cycle low pulse must be rejected
        base = flagCount;
        applyStimulus(1'b1, n);
        waitCycles(25);
        checkOutput("release2_count", flagCount - base, 1);
        checkOutput("release2_state", int'(keyState), 1);
        base = flagCount;
        applyStimulus(1'b0, n);
        waitCycles(14);
        applyStimulus(1'b1, n);
        waitCycles(30);
        checkOutput("short_pulse_count", flagCount - base, 0);
        checkOutput("short_pulse_state", int'(keyState), 1);

        // Test 6: reset while filtering a press with cnt at 10
        base = flagCount;
        applyStimulus(1'b0, n);
        waitCycles(12);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midreset_flag", int'(keyFlag), 0);
        checkOutput("midreset_state", int'(keyState), 1);
        waitCycles(1);
        checkOutput("midreset_flag2", int'(keyFlag), 0);
        rst = 1'b0;
        n = edgeCnt + 1;
        checkOutput("midreset_count", flagCount - base, 0);
        waitCycles(25);
        checkOutput("postreset_count", flagCount - base, 1);
        checkOutput("postreset_edge", lastFlagEdge, n + LAT);
        checkOutput("postreset_state", int'(keyState), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
